// File: rtl/bomb_placer.sv
// bomb_placer: turns A/B bomb button pulses into legal, arbitrated single-cell bomb-map writes
module bomb_placer #(
  parameter int GRID      = 10,
  parameter int MAX_BOMBS = 2,
  parameter int FUSE      = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bombTick,
  input  logic                     btnA,
  input  logic                     btnB,
  input  logic [3:0]               posAX,
  input  logic [3:0]               posAY,
  input  logic [3:0]               posBX,
  input  logic [3:0]               posBY,
  input  logic [1:0]               healthA,
  input  logic [1:0]               healthB,
  input  logic [2*GRID*GRID-1:0]   curBombMap,
  input  logic [2*GRID*GRID-1:0]   curArena,
  output logic                     wrEn,
  output logic [3:0]               wrX,
  output logic [3:0]               wrY,
  output logic [1:0]               wrVal,
  output logic [1:0]               activeA,
  output logic [1:0]               activeB,
  output logic                     rejA,
  output logic                     rejB
);
  localparam int IW = $clog2(2*GRID*GRID);
  logic [1:0] pend_q, pend_d, rej_q, rej_d;
  logic [1:0][3:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic [1:0][MAX_BOMBS-1:0][1:0] tmr_q, tmr_d;
  logic ptr_q, ptr_d, wb_valid_q, wb_valid_d, last_valid_q, last_valid_d;
  logic [3:0] wb_x_q, wb_x_d, wb_y_q, wb_y_d, last_x_q, last_x_d, last_y_q, last_y_d;
  logic [1:0] btn;
  logic [1:0][3:0] pos_x, pos_y;
  logic [1:0][1:0] hp, act;
  logic win, go, ok, in_rng, dup, found;
  logic [3:0] wx, wy;
  logic [IW-1:0] idx;
  logic [1:0] arena_cell, map_cell;
  assign btn   = {btnB, btnA};
  assign pos_x = {posBX, posAX};
  assign pos_y = {posBY, posAY};
  assign hp    = {healthB, healthA};
  assign wrEn    = wb_valid_q & ~bombTick;
  assign wrX     = wb_x_q;
  assign wrY     = wb_y_q;
  assign wrVal   = {1'b0, wb_valid_q};
  assign activeA = act[0];
  assign activeB = act[1];
  assign rejA    = rej_q[0];
  assign rejB    = rej_q[1];
  always_comb begin
    act = '0;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < MAX_BOMBS; s++)
        act[p] = act[p] + 2'(tmr_q[p][s] != 2'd0);
  end
  // Arbitration never runs in a tick cycle, so the buffer is always free or draining when it does.
  always_comb begin
    win        = &pend_q ? ptr_q : pend_q[1];
    go         = ~bombTick & |pend_q;
    wx         = pend_x_q[win];
    wy         = pend_y_q[win];
    in_rng     = int'(wx) < GRID && int'(wy) < GRID;
    idx        = in_rng ? IW'(2 * (GRID * int'(wy) + int'(wx))) : '0;
    arena_cell = curArena[idx +: 2];
    map_cell   = curBombMap[idx +: 2];
    dup        = (wb_valid_q && wx == wb_x_q && wy == wb_y_q) ||
                 (last_valid_q && wx == last_x_q && wy == last_y_q);
    ok         = in_rng && hp[win] != 2'd0 && int'(act[win]) < MAX_BOMBS &&
                 arena_cell != 2'd1 && map_cell == 2'd0 && !dup;
  end
  always_comb begin
    pend_d       = pend_q;
    pend_x_d     = pend_x_q;
    pend_y_d     = pend_y_q;
    rej_d        = '0;
    ptr_d        = ptr_q;
    tmr_d        = tmr_q;
    found        = 1'b0;
    wb_valid_d   = wrEn ? 1'b0 : wb_valid_q;
    wb_x_d       = wb_x_q;
    wb_y_d       = wb_y_q;
    last_valid_d = wrEn;
    last_x_d     = wrEn ? wb_x_q : last_x_q;
    last_y_d     = wrEn ? wb_y_q : last_y_q;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < MAX_BOMBS; s++)
        if (bombTick && tmr_q[p][s] != 2'd0) tmr_d[p][s] = tmr_q[p][s] - 2'd1;
    if (go) begin
      pend_d[win] = 1'b0;
      ptr_d       = ~win;
      rej_d[win]  = ~ok;
      if (ok) begin
        wb_valid_d = 1'b1;
        wb_x_d     = wx;
        wb_y_d     = wy;
        for (int s = 0; s < MAX_BOMBS; s++)
          if (!found && tmr_q[win][s] == 2'd0) begin
            tmr_d[win][s] = 2'(FUSE);
            found         = 1'b1;
          end
      end
    end
    for (int p = 0; p < 2; p++)
      if (btn[p] && !pend_q[p]) begin
        pend_d[p]   = 1'b1;
        pend_x_d[p] = pos_x[p];
        pend_y_d[p] = pos_y[p];
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q       <= '0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      rej_q        <= '0;
      tmr_q        <= '0;
      ptr_q        <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_x_q       <= '0;
      wb_y_q       <= '0;
      last_valid_q <= 1'b0;
      last_x_q     <= '0;
      last_y_q     <= '0;
    end else begin
      pend_q       <= pend_d;
      pend_x_q     <= pend_x_d;
      pend_y_q     <= pend_y_d;
      rej_q        <= rej_d;
      tmr_q        <= tmr_d;
      ptr_q        <= ptr_d;
      wb_valid_q   <= wb_valid_d;
      wb_x_q       <= wb_x_d;
      wb_y_q       <= wb_y_d;
      last_valid_q <= last_valid_d;
      last_x_q     <= last_x_d;
      last_y_q     <= last_y_d;
    end
  end
endmodule
